// File: rtl/reg_load_arbiter_pkg.sv
// Shared definitions for the reg_load_arbiter block.
//  - arb_state_t : two-state FSM encoding (ARB_IDLE = 0, ARB_LOAD = 1)
//  - ID_W        : width of requester indices (supports up to 8 requesters)
//  - next_index  : round-robin successor of a requester index
package reg_load_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOAD = 1'b1
    } arb_state_t;

    localparam int ID_W     = 3;
    localparam int MAX_NREQ = 8;
    localparam int DEF_DW   = 16;

    // Index that follows idx in an n-entry ring; wraps n-1 back to 0.
    function automatic logic [ID_W-1:0] next_index(input logic [ID_W-1:0] idx, input int n);
        return ID_W'((int'(idx) + 1) % n);
    endfunction

endpackage

// File: rtl/reg_load_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//  req   in  NREQ  request vector
//  ptr   in  3     highest-priority index for this pick (must be < NREQ)
//  win   out 3     first set request at or after ptr, wrapping modulo NREQ
//  valid out 1     at least one request is set (win is meaningful)
module reg_load_arbiter_rr_pick
    import reg_load_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] win,
    output logic            valid
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // rot[k] is the request that sits k places after the pointer.
    logic [NREQ-1:0] rot;
    int              off;
    logic            found;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            assign rot[gi] = req[IW'((int'(ptr) + gi) % NREQ)];
        end
    endgenerate

    always_comb begin
        off   = 0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
    end

    assign win   = ID_W'((int'(ptr) + off) % NREQ);
    assign valid = |req;

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing one DW-bit load/data-in register among NREQ writers.
// A request seen in IDLE is captured and written in the following LOAD cycle,
// where load_out, gnt and busy are high for exactly one cycle. All outputs
// come straight from flops, so there is no combinational path from req.
// Optional feature macro: REG_ARB_LOCK_EN (adds lock port, MAX_LOCK and a
// lock counter that lets a requester keep the grant for consecutive beats).
// Ports:
//  clk       in  1        rising-edge clock
//  rst       in  1        asynchronous active-high reset
//  req       in  NREQ     level write requests
//  req_data  in  NREQ*DW  write data, requester i at [i*DW +: DW]
//  lock      in  NREQ     keep grant for next beat (REG_ARB_LOCK_EN only)
//  gnt       out NREQ     one-hot acknowledge, coincides with load_out
//  load_out  out 1        register load strobe
//  data_out  out DW       register data-in, holds last value between beats
//  busy      out 1        high during the LOAD cycle
//  gnt_id    out 3        index of the most recently granted requester
module reg_load_arbiter
    import reg_load_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DEF_DW
`ifdef REG_ARB_LOCK_EN
    ,
    parameter int MAX_LOCK = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
`ifdef REG_ARB_LOCK_EN
    input  logic [NREQ-1:0]      lock,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic                 load_out,
    output logic [DW-1:0]        data_out,
    output logic                 busy,
    output logic [ID_W-1:0]      gnt_id
);

    arb_state_t      state_reg, state_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic            load_reg, load_next;
    logic            busy_reg, busy_next;
    logic [DW-1:0]   data_reg, data_next;
    logic [ID_W-1:0] gnt_id_reg, gnt_id_next;
    logic [ID_W-1:0] ptr_reg, ptr_next;

    logic [NREQ-1:0] pick_req;
    logic [ID_W-1:0] pick_win;
    logic            pick_valid;
    logic [NREQ-1:0] gnt_mask;
    logic            own_req;

    assign gnt_mask = NREQ'(1) << gnt_id_reg;
    assign own_req  = |(req & gnt_mask);

`ifdef REG_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK) + 1;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             hold_reg, hold_next;
    logic             own_lock;

    assign own_lock = |(lock & gnt_mask);
    // While held, only the lock owner may win; if it has gone quiet the
    // hold is dropped and everyone competes normally in the same cycle.
    assign pick_req = (hold_reg && own_req) ? gnt_mask : req;
`else
    assign pick_req = req;
`endif

    reg_load_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr_reg),
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        gnt_next    = '0;
        load_next   = 1'b0;
        busy_next   = 1'b0;
        data_next   = data_reg;
        gnt_id_next = gnt_id_reg;
        ptr_next    = ptr_reg;
`ifdef REG_ARB_LOCK_EN
        cnt_next    = cnt_reg;
        hold_next   = hold_reg;
`endif
        case (state_reg)
            ARB_IDLE: begin
`ifdef REG_ARB_LOCK_EN
                if (hold_reg && !own_req) begin
                    hold_next = 1'b0;
                end
`endif
                // Outputs for the LOAD cycle are prepared here so they
                // leave the flops already valid.
                if (pick_valid) begin
                    data_next   = req_data[int'(pick_win)*DW +: DW];
                    gnt_id_next = pick_win;
                    gnt_next    = NREQ'(1) << pick_win;
                    load_next   = 1'b1;
                    busy_next   = 1'b1;
                    state_next  = ARB_LOAD;
                end
            end
            ARB_LOAD: begin
                state_next = ARB_IDLE;
`ifdef REG_ARB_LOCK_EN
                if (own_lock && (cnt_reg < CNT_W'(MAX_LOCK - 1))) begin
                    cnt_next  = cnt_reg + 1'b1;
                    hold_next = 1'b1;
                end else begin
                    // Either no lock, or the lock ran out its beat budget.
                    ptr_next  = next_index(gnt_id_reg, NREQ);
                    cnt_next  = '0;
                    hold_next = 1'b0;
                end
`else
                ptr_next = next_index(gnt_id_reg, NREQ);
`endif
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_reg    <= '0;
            load_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            data_reg   <= '0;
            gnt_id_reg <= '0;
            ptr_reg    <= '0;
`ifdef REG_ARB_LOCK_EN
            cnt_reg    <= '0;
            hold_reg   <= 1'b0;
`endif
        end else begin
            gnt_reg    <= gnt_next;
            load_reg   <= load_next;
            busy_reg   <= busy_next;
            data_reg   <= data_next;
            gnt_id_reg <= gnt_id_next;
            ptr_reg    <= ptr_next;
`ifdef REG_ARB_LOCK_EN
            cnt_reg    <= cnt_next;
            hold_reg   <= hold_next;
`endif
        end
    end

    assign gnt      = gnt_reg;
    assign load_out = load_reg;
    assign busy     = busy_reg;
    assign data_out = data_reg;
    assign gnt_id   = gnt_id_reg;

endmodule
